// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - issue-class encodings and bubble helper for the issue scoreboard
package pipe_pkg;

  localparam logic [1:0] CLASS_ALU  = 2'd0;
  localparam logic [1:0] CLASS_LOAD = 2'd1;
  localparam logic [1:0] CLASS_MUL  = 2'd2;
  localparam logic [1:0] CLASS_RSVD = 2'd3;

  // Number of cycles a consumer must wait after the producer issues.
  // Reserved class behaves as ALU.
  function automatic int unsigned class_bubbles(input logic [1:0] cls,
                                                input int unsigned load_lat,
                                                input int unsigned mul_lat);
    case (cls)
      CLASS_LOAD: return load_lat - 1;
      CLASS_MUL:  return mul_lat - 1;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - loadable saturating-at-zero down-counter with nonzero flag
module sb_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         nz
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over the decrement; an idle counter rests at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nz = (cnt_q != '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - per-register pending-write scoreboard issuing or stalling decode
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 4,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2((LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rs,
  input  logic [REG_AW-1:0]   issue_rt,
  input  logic                issue_uses_rs,
  input  logic                issue_uses_rt,
  input  logic                issue_wr_en,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic [1:0]          issue_class,
  input  logic                flush,
  output logic                stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [31:0]         stall_count
);

  if (LOAD_LAT < 1 || MUL_LAT < 1 || NUM_REGS < 2 ||
      (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_param_check
    $error("pipe_scoreboard: illegal LOAD_LAT/MUL_LAT/NUM_REGS");
  end

  logic [NUM_REGS-1:0] busy;
  logic                mul_busy;
  logic [CNT_W-1:0]    bubbles;
  logic                hazard;
  logic                rd_load;
  logic                mul_load;
  logic [31:0]         stall_count_q;
  logic [31:0]         stall_count_d;

  // Decode the issuing instruction's class into a wait count and detect hazards.
  always_comb begin
    bubbles = CNT_W'(class_bubbles(issue_class, LOAD_LAT, MUL_LAT));
    hazard  = issue_valid &
              ((issue_uses_rs & busy[issue_rs]) |
               (issue_uses_rt & busy[issue_rt]) |
               (issue_wr_en   & busy[issue_rd]) |
               ((issue_class == CLASS_MUL) & mul_busy));
  end

  assign stall      = hazard;
  assign issue_fire = issue_valid & ~hazard & ~flush;
  assign rd_load    = issue_fire & issue_wr_en & (issue_rd != '0) & (bubbles != '0);
  assign mul_load   = issue_fire & (issue_class == CLASS_MUL);

  // Register zero never has a pending write.
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (rd_load & (issue_rd == REG_AW'(r))),
      .load_val (bubbles),
      .nz       (busy[r])
    );
  end

  sb_counter #(.W(CNT_W)) u_mul_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_load),
    .load_val (CNT_W'(MUL_LAT - 1)),
    .nz       (mul_busy)
  );

  // Count cycles lost to hazards; a flushed instruction is not a lost cycle.
  always_comb begin
    stall_count_d = stall_count_q;
    if (issue_valid && hazard && !flush && stall_count_q != 32'hFFFF_FFFF) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign busy_mask   = busy;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - self-checking bench for pipe_scoreboard against a cycle-time model
module tb_pipe_scoreboard;

  localparam int NR       = 32;
  localparam int AW       = 5;
  localparam int LOAD_LAT = 2;
  localparam int MUL_LAT  = 4;

  logic          clk;
  logic          reset_n;
  logic          issue_valid;
  logic [AW-1:0] issue_rs;
  logic [AW-1:0] issue_rt;
  logic          issue_uses_rs;
  logic          issue_uses_rt;
  logic          issue_wr_en;
  logic [AW-1:0] issue_rd;
  logic [1:0]    issue_class;
  logic          flush;
  logic          stall;
  logic          issue_fire;
  logic [NR-1:0] busy_mask;
  logic [31:0]   stall_count;

  int errors = 0;
  int checks = 0;

  // Reference model: absolute cycle at which each register / the multiplier is free.
  int unsigned ready_at[NR];
  int unsigned mul_free_at;
  int unsigned cyc;
  logic [31:0] m_sc;
  logic        exp_stall;
  logic        exp_fire;
  logic [NR-1:0] exp_busy;

  pipe_scoreboard #(.NUM_REGS(NR), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk           (clk),
    .reset         (reset_n),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_uses_rs (issue_uses_rs),
    .issue_uses_rt (issue_uses_rt),
    .issue_wr_en   (issue_wr_en),
    .issue_rd      (issue_rd),
    .issue_class   (issue_class),
    .flush         (flush),
    .stall         (stall),
    .issue_fire    (issue_fire),
    .busy_mask     (busy_mask),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) ready_at[r] = 0;
    mul_free_at = 0;
    m_sc = 32'd0;
  endfunction

  function automatic void model_eval();
    exp_busy = '0;
    for (int r = 1; r < NR; r++) if (cyc < ready_at[r]) exp_busy[r] = 1'b1;
    exp_stall = issue_valid &&
                ((issue_uses_rs && exp_busy[issue_rs]) ||
                 (issue_uses_rt && exp_busy[issue_rt]) ||
                 (issue_wr_en && exp_busy[issue_rd]) ||
                 (issue_class == 2'd2 && cyc < mul_free_at));
    exp_fire = issue_valid && !exp_stall && !flush;
  endfunction

  task automatic tick();
    int unsigned lat;
    model_eval();
    if (exp_fire) begin
      lat = (issue_class == 2'd1) ? LOAD_LAT : (issue_class == 2'd2) ? MUL_LAT : 1;
      if (issue_wr_en && issue_rd != 0 && lat > 1) ready_at[issue_rd] = cyc + lat;
      if (issue_class == 2'd2) mul_free_at = cyc + MUL_LAT;
    end
    if (issue_valid && exp_stall && !flush && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                       input logic urt, input logic wr, input int rd,
                       input logic [1:0] cls, input logic fl);
    issue_valid   = v;
    issue_rs      = AW'(rs);
    issue_rt      = AW'(rt);
    issue_uses_rs = urs;
    issue_uses_rt = urt;
    issue_wr_en   = wr;
    issue_rd      = AW'(rd);
    issue_class   = cls;
    flush         = fl;
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    model_reset();
    checks++;
    if (busy_mask !== '0 || stall_count !== 32'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: busy=%h cnt=%0d stall=%b required 0/0/0", busy_mask, stall_count, stall);
    end
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_n = 1'b1;
    #1;
    drive(1, 1, 2, 1, 1, 1, 3, 2'd2, 0);
    checks++;
    if (issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL reset_mul_fire: got %b required 1", issue_fire);
    end
    tick();
    drive(1, 5, 6, 1, 1, 1, 4, 2'd2, 0);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_mul_busy: stall=%b required 1", stall);
    end
    tick();
    checks++;
    if (stall_count !== 32'd1) begin
      errors++;
      $display("FAIL reset_prestall_count: got %0d required 1", stall_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy_mask !== '0 || stall !== 1'b0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_midstall: busy=%h stall=%b cnt=%0d required 0/0/0", busy_mask, stall, stall_count);
    end
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    reset_n = 1'b1;
    #1;
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] sc0;
    drive(1, 1, 2, 1, 0, 1, 5, 2'd1, 0);
    checks++;
    if (issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL load_fire: got %b required 1", issue_fire);
    end
    tick();
    sc0 = m_sc;
    drive(1, 5, 1, 1, 1, 1, 6, 2'd0, 0);
    checks++;
    if (stall !== 1'b1 || issue_fire !== 1'b0 || busy_mask[5] !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b fire=%b busy5=%b required 1/0/1", stall, issue_fire, busy_mask[5]);
    end
    tick();
    checks++;
    if (issue_fire !== 1'b1 || stall !== 1'b0 || stall_count !== sc0 + 32'd1) begin
      errors++;
      $display("FAIL load_use_release: fire=%b stall=%b cnt=%0d required 1/0/%0d", issue_fire, stall, stall_count, sc0 + 1);
    end
    tick();
    idle(1);
  endtask

  task automatic test_mul_back_to_back();
    drive(1, 1, 2, 1, 1, 1, 7, 2'd2, 0);
    checks++;
    if (issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL mul_first_fire: got %b required 1", issue_fire);
    end
    tick();
    drive(1, 3, 4, 1, 1, 1, 8, 2'd2, 0);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (stall !== 1'b1 || issue_fire !== 1'b0 || busy_mask[7] !== 1'b1) begin
        errors++;
        $display("FAIL mul_busy_t%0d: stall=%b fire=%b busy7=%b required 1/0/1", i, stall, issue_fire, busy_mask[7]);
      end
      tick();
    end
    checks++;
    if (issue_fire !== 1'b1 || busy_mask[7] !== 1'b0) begin
      errors++;
      $display("FAIL mul_second_fire: fire=%b busy7=%b required 1/0", issue_fire, busy_mask[7]);
    end
    tick();
    idle(4);
  endtask

  task automatic test_r0();
    drive(1, 1, 2, 1, 1, 1, 0, 2'd1, 0);
    tick();
    drive(1, 0, 0, 1, 1, 1, 11, 2'd0, 0);
    checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1 || busy_mask !== '0) begin
      errors++;
      $display("FAIL r0_no_hazard: stall=%b fire=%b busy=%h required 0/1/0", stall, issue_fire, busy_mask);
    end
    tick();
    idle(1);
  endtask

  task automatic test_waw_flush();
    logic [31:0] sc0;
    drive(1, 1, 2, 1, 1, 1, 9, 2'd2, 0);
    tick();
    sc0 = m_sc;
    drive(1, 1, 2, 1, 1, 1, 9, 2'd0, 1);
    checks++;
    if (stall !== 1'b1 || issue_fire !== 1'b0) begin
      errors++;
      $display("FAIL waw_flush: stall=%b fire=%b required 1/0", stall, issue_fire);
    end
    tick();
    checks++;
    if (stall_count !== sc0) begin
      errors++;
      $display("FAIL waw_flush_count: got %0d required %0d", stall_count, sc0);
    end
    drive(1, 1, 2, 1, 1, 1, 9, 2'd0, 0);
    for (int i = 2; i <= 3; i++) begin
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL waw_stall_t%0d: stall=%b required 1", i, stall);
      end
      tick();
    end
    checks++;
    if (issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL waw_release: fire=%b required 1", issue_fire);
    end
    tick();
    idle(1);
  endtask

  task automatic test_random();
    int cls;
    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(0, 3);
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 2'(cls), ($urandom_range(0, 9) == 0));
      model_eval();
      checks++;
      if (stall !== exp_stall || issue_fire !== exp_fire || busy_mask !== exp_busy ||
          stall_count !== m_sc) begin
        errors++;
        $display("FAIL random_c%0d: stall=%b fire=%b busy=%h cnt=%0d required %b/%b/%h/%0d",
                 n, stall, issue_fire, busy_mask, stall_count, exp_stall, exp_fire, exp_busy, m_sc);
      end
      tick();
    end
    idle(5);
  endtask

  task automatic test_saturate();
    drive(1, 1, 2, 1, 1, 1, 10, 2'd2, 0);
    tick();
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    m_sc = 32'hFFFF_FFFE;
    drive(1, 10, 1, 1, 1, 1, 12, 2'd0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (stall_count !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL saturate_c%0d: got %h required ffffffff", i, stall_count);
      end
    end
    idle(1);
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_load_use();
    test_mul_back_to_back();
    test_r0();
    test_waw_flush();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
